ramp_envelope_applier: RTL and testbench

RAMP_ENVELOPE_APPLIER -- requirements
Module: ramp_envelope_applier

---
 rtl/ramp_envelope_applier_pkg.sv | 13 +
 rtl/ramp_envelope_applier_if.sv | 22 ++
 rtl/ramp_envelope_applier_pipe_ctrl.sv | 29 ++
 rtl/ramp_envelope_applier.sv | 120 ++++++++++++
 tb/tb_ramp_envelope_applier.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ramp_envelope_applier_pkg.sv
// signal_ramp_pkg: constants and state codes shared between the ramper and the envelope applier.
package signal_ramp_pkg;
    localparam int RAMP_MAX   = 8191;
    localparam int RAMP_SHIFT = 13;

    typedef enum logic [2:0] {
        RS_RAMP_UP   = 3'd0,
        RS_NORMAL    = 3'd1,
        RS_REQ_DOWN  = 3'd2,
        RS_RAMP_DOWN = 3'd3,
        RS_DONE      = 3'd4
    } ramp_state_e;
endpackage

// File: rtl/ramp_envelope_applier_if.sv
// ramp_envelope_applier_if: sample stream in/out plus the ramper side-band (envelope, state, done flag).
interface ramp_envelope_applier_if #(parameter int SAMPLE_W = 16);
    logic signed [SAMPLE_W-1:0] s_axis_tdata;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic [15:0]                ramp;
    logic [2:0]                 rampState;
    logic signed [SAMPLE_W-1:0] m_axis_tdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic                       rampDone;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, ramp, rampState, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, rampDone
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, ramp, rampState, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, rampDone
    );
endinterface

// File: rtl/ramp_envelope_applier_pipe_ctrl.sv
// axis_pipe_ctrl: common advance enable and stage-valid shift register for a fixed-depth stream pipeline.
module axis_pipe_ctrl #(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              s_valid_i,
    input  logic              m_ready_i,
    output logic              s_ready_o,
    output logic              adv_o,
    output logic              hs_o,
    output logic [STAGES:1]   vld_o
);
    logic [STAGES:1] vld_q, vld_d;
    logic [STAGES:0] vld_pipe;

    // The whole pipe moves as one; it freezes only when the output stage is full and blocked.
    assign adv_o     = ~vld_q[STAGES] | m_ready_i;
    assign s_ready_o = adv_o;
    assign hs_o      = s_valid_i & adv_o;
    assign vld_pipe  = {vld_q, hs_o};
    assign vld_d     = adv_o ? vld_pipe[STAGES-1:0] : vld_q;
    assign vld_o     = vld_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) vld_q <= '0;
        else          vld_q <= vld_d;
    end
endmodule

// File: rtl/ramp_envelope_applier.sv
// ramp_envelope_applier: scales a signed sample stream by a 0..RAMP_MAX envelope (capture, multiply, round/saturate).
// Define RAMP_ENV_ROUND_EN for round-half-up; otherwise the shift truncates toward minus infinity.
module ramp_envelope_applier #(
    parameter int SAMPLE_W = 16,
    parameter int RAMP_MAX = signal_ramp_pkg::RAMP_MAX
) (
    input  logic                   clk,
    input  logic                   aresetn,
    ramp_envelope_applier_if.slave bus
);
    import signal_ramp_pkg::*;

    localparam int STAGES = 3;
    localparam int PROD_W = SAMPLE_W + 17;
    localparam int ACC_W  = PROD_W + 1;
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic              adv, hs, s_ready;
    logic [STAGES:1]   vld;

    axis_pipe_ctrl #(.STAGES(STAGES)) u_ctrl (
        .clk       (clk),
        .aresetn   (aresetn),
        .s_valid_i (bus.s_axis_tvalid),
        .m_ready_i (bus.m_axis_tready),
        .s_ready_o (s_ready),
        .adv_o     (adv),
        .hs_o      (hs),
        .vld_o     (vld)
    );

    assign bus.s_axis_tready = s_ready;

    // Stage 1: capture sample, envelope and state together.
    logic signed [SAMPLE_W-1:0] s1_data_q;
    logic [15:0]                s1_ramp_q;
    logic                       s1_done_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_data_q <= '0;
            s1_ramp_q <= '0;
            s1_done_q <= 1'b0;
        end else if (hs) begin
            s1_data_q <= bus.s_axis_tdata;
            s1_ramp_q <= bus.ramp;
            s1_done_q <= (bus.rampState == RS_DONE);
        end
    end

    // Stage 2: clamp and multiply; unity gain is flagged so it can bypass the shift error.
    logic [15:0]                ramp_clamped;
    logic signed [PROD_W-1:0]   a_ext, b_ext, prod_d;
    logic signed [PROD_W-1:0]   s2_prod_q;
    logic signed [SAMPLE_W-1:0] s2_data_q;
    logic                       s2_bypass_q, s2_done_q;

    assign ramp_clamped = (s1_ramp_q > 16'(RAMP_MAX)) ? 16'(RAMP_MAX) : s1_ramp_q;
    assign a_ext        = PROD_W'(s1_data_q);
    assign b_ext        = PROD_W'($signed({1'b0, ramp_clamped}));
    assign prod_d       = a_ext * b_ext;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s2_prod_q   <= '0;
            s2_data_q   <= '0;
            s2_bypass_q <= 1'b0;
            s2_done_q   <= 1'b0;
        end else if (adv && vld[1]) begin
            s2_prod_q   <= prod_d;
            s2_data_q   <= s1_data_q;
            s2_bypass_q <= (ramp_clamped == 16'(RAMP_MAX));
            s2_done_q   <= s1_done_q;
        end
    end

    // Stage 3: optional rounding, shift, saturate.
    logic signed [ACC_W-1:0]    acc, shifted;
    logic signed [SAMPLE_W-1:0] sat_d, out_d;
    logic signed [SAMPLE_W-1:0] m_tdata_q;
    logic                       s3_done_q, done_q;

`ifdef RAMP_ENV_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (RAMP_SHIFT - 1);
    assign acc = ACC_W'(s2_prod_q) + ROUND_HALF;
`else
    assign acc = ACC_W'(s2_prod_q);
`endif

    assign shifted = acc >>> RAMP_SHIFT;

    always_comb begin
        sat_d = shifted[SAMPLE_W-1:0];
        if (shifted > SMAX)      sat_d = SMAX[SAMPLE_W-1:0];
        else if (shifted < SMIN) sat_d = SMIN[SAMPLE_W-1:0];
    end

    assign out_d = s2_bypass_q ? s2_data_q : sat_d;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata_q <= '0;
            s3_done_q <= 1'b0;
        end else if (adv && vld[2]) begin
            m_tdata_q <= out_d;
            s3_done_q <= s2_done_q;
        end
    end

    // Sticky until reset: raised only when the done-state sample actually leaves.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)                                   done_q <= 1'b0;
        else if (vld[STAGES] && bus.m_axis_tready && s3_done_q) done_q <= 1'b1;
    end

    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tvalid = vld[STAGES];
    assign bus.rampDone      = done_q;
endmodule

// File: tb/tb_ramp_envelope_applier.sv
// tb_ramp_envelope_applier: directed vector table, stall/done/reset sequences and randomized scoreboard run.
module tb_ramp_envelope_applier;
    localparam int SW   = 16;
    localparam int RMAX = 8191;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    ramp_envelope_applier_if #(.SAMPLE_W(SW)) bus();

    ramp_envelope_applier #(.SAMPLE_W(SW), .RAMP_MAX(RMAX)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        longint val;
        bit     done;
    } exp_t;

    typedef struct {
        string                 nm;
        logic signed [SW-1:0]  d;
        logic [15:0]           r;
        logic signed [SW-1:0]  ex;
    } vec_t;

    exp_t   sbq[$];
    bit     done_exp;
    bit     prev_stall;
    longint prev_data;
    bit     last_acc;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Envelope rule in plain integer arithmetic: clamp, unity bypass, floor(product/8192), saturate.
    function automatic longint model(input longint s, input longint r);
        longint g, p, q;
        g = (r > RMAX) ? RMAX : r;
        if (g == RMAX) return s;
        p = s * g;
`ifdef RAMP_ENV_ROUND_EN
        p = p + 4096;
`endif
        q = p / 8192;
        if (p < 0 && q * 8192 != p) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    // One clock of streaming with scoreboard, stall-stability and rampDone tracking.
    task automatic step(input bit vin, input logic signed [SW-1:0] din, input logic [15:0] rin,
                        input logic [2:0] stin, input bit rdy);
        exp_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid_held", bus.m_axis_tvalid, 1);
            chk("stall_data_held", bus.m_axis_tdata, prev_data);
        end
        chk("rampDone", bus.rampDone, done_exp);
        bus.s_axis_tvalid = vin;
        bus.s_axis_tdata  = din;
        bus.ramp          = rin;
        bus.rampState     = stin;
        bus.m_axis_tready = rdy;
        #1;
        chk("s_ready", bus.s_axis_tready, (!bus.m_axis_tvalid || rdy) ? 1 : 0);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (sbq.size() == 0) chk("spurious_out", bus.m_axis_tvalid, 0);
            else begin
                e = sbq.pop_front();
                chk("out_data", bus.m_axis_tdata, e.val);
                if (e.done) done_exp = 1'b1;
            end
        end
        last_acc = bus.s_axis_tvalid && bus.s_axis_tready;
        if (last_acc) begin
            e.val  = model(din, rin);
            e.done = (stin == 3'b100);
            sbq.push_back(e);
        end
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_data  = bus.m_axis_tdata;
    endtask

    // Single sample into an empty pipe with tready high: output must appear exactly 3 cycles later.
    task automatic apply_vec(input string nm, input logic signed [SW-1:0] d, input logic [15:0] r,
                             input logic signed [SW-1:0] ex);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.ramp          = r;
        bus.rampState     = 3'd1;
        bus.m_axis_tready = 1'b1;
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        chk({nm, "_lat1_valid"}, bus.m_axis_tvalid, 0);
        @(negedge clk);
        chk({nm, "_lat2_valid"}, bus.m_axis_tvalid, 0);
        @(negedge clk);
        chk({nm, "_lat3_valid"}, bus.m_axis_tvalid, 1);
        chk({nm, "_data"}, bus.m_axis_tdata, ex);
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        aresetn = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        #1;
        chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_m_tdata", bus.m_axis_tdata, 0);
        chk("rst_rampDone", bus.rampDone, 0);
        sbq.delete();
        done_exp   = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1;
        chk("rst_exit_s_ready", bus.s_axis_tready, 1);
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.ramp          = '0;
        bus.rampState     = '0;
        bus.m_axis_tready = 1'b0;
        done_exp = 1'b0; prev_stall = 1'b0; prev_data = 0; last_acc = 1'b0;

        #1;
        chk("init_m_tvalid", bus.m_axis_tvalid, 0);
        chk("init_m_tdata", bus.m_axis_tdata, 0);
        chk("init_rampDone", bus.rampDone, 0);
        chk("init_s_ready", bus.s_axis_tready, 1);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;

        // Hand-derived expectations; rounding changes only the inexact cases.
        v = '{"half_gain",   16'sd1000,   16'd4096,  16'sd500};    vecs.push_back(v);
        v = '{"neg_half",   -16'sd1000,   16'd4096, -16'sd500};    vecs.push_back(v);
        v = '{"unity_max",   16'sd32767,  16'd8191,  16'sd32767};  vecs.push_back(v);
        v = '{"clamp_9000",  16'sd32767,  16'd9000,  16'sd32767};  vecs.push_back(v);
        v = '{"clamp_8192",  16'sd16384,  16'd8192,  16'sd16384};  vecs.push_back(v);
        v = '{"clamp_ffff",  16'sd32767,  16'hFFFF,  16'sd32767};  vecs.push_back(v);
        v = '{"min_zero",   -16'sd32768,  16'd0,     16'sd0};      vecs.push_back(v);
        v = '{"min_unity",  -16'sd32768,  16'd8191, -16'sd32768};  vecs.push_back(v);
`ifdef RAMP_ENV_ROUND_EN
        v = '{"m1_half",    -16'sd1,      16'd4096,  16'sd0};      vecs.push_back(v);
        v = '{"near_unity",  16'sd100,    16'd8190,  16'sd100};    vecs.push_back(v);
        v = '{"tiny_neg",   -16'sd3,      16'd1,     16'sd0};      vecs.push_back(v);
        v = '{"big_neg",    -16'sd20000,  16'd8190, -16'sd19995};  vecs.push_back(v);
`else
        v = '{"m1_half",    -16'sd1,      16'd4096, -16'sd1};      vecs.push_back(v);
        v = '{"near_unity",  16'sd100,    16'd8190,  16'sd99};     vecs.push_back(v);
        v = '{"tiny_neg",   -16'sd3,      16'd1,    -16'sd1};      vecs.push_back(v);
        v = '{"big_neg",    -16'sd20000,  16'd8190, -16'sd19996};  vecs.push_back(v);
`endif
        for (int i = 0; i < vecs.size(); i++)
            apply_vec(vecs[i].nm, vecs[i].d, vecs[i].r, vecs[i].ex);

        // Stream 1..10 at unity with a 5-cycle downstream stall mid-stream.
        begin
            int nxt;
            bit rdy;
            nxt = 1;
            for (int c = 0; c < 40; c++) begin
                rdy = !(c >= 5 && c < 10);
                step(nxt <= 10, 16'(nxt), 16'd8191, 3'd1, rdy);
                if (last_acc) nxt++;
            end
            chk("stream_accepted", nxt, 11);
            chk("stream_drained", sbq.size(), 0);
        end

        // Randomized traffic with random backpressure against the model.
        begin
            logic signed [SW-1:0] d;
            logic [15:0] r;
            logic [2:0]  st;
            bit vin, rdy;
            for (int c = 0; c < 400; c++) begin
                d = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: r = 16'd0;
                    1: r = 16'd8191;
                    2: r = 16'($urandom_range(8192, 65535));
                    default: r = 16'($urandom_range(1, 8190));
                endcase
                st  = ($urandom_range(0, 19) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
                vin = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 9) < 7);
                step(vin, d, r, st, rdy);
            end
            for (int c = 0; c < 8; c++) step(1'b0, '0, '0, 3'd0, 1'b1);
            chk("random_drained", sbq.size(), 0);
        end

        // rampDone rises on the third sample's output handshake and is cleared only by reset.
        do_reset();
        step(1'b1, 16'sd10, 16'd8191, 3'd1, 1'b1);
        step(1'b1, 16'sd20, 16'd8191, 3'd1, 1'b1);
        step(1'b1, 16'sd30, 16'd8191, 3'd4, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, '0, '0, 3'd0, 1'b1);
        chk("done_sticky", bus.rampDone, 1);
        do_reset();

        // Three samples in flight at reset: none may emerge afterwards.
        step(1'b1, 16'sd111, 16'd8191, 3'd1, 1'b1);
        step(1'b1, 16'sd222, 16'd8191, 3'd1, 1'b1);
        step(1'b1, 16'sd333, 16'd8191, 3'd1, 1'b1);
        do_reset();
        for (int c = 0; c < 6; c++) step(1'b0, '0, '0, 3'd0, 1'b1);
        chk("post_reset_idle_valid", bus.m_axis_tvalid, 0);
        apply_vec("post_reset", 16'sd1000, 16'd4096, 16'sd500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
